// File: rtl/mux4x1_pkg.sv
// Shared constants and types for the registered 4:1 lane multiplexer.
package mux4x1_pkg;
    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux4x1_lane_sel.sv
// Combinational W-bit 4:1 lane selector: lane k is din[k*W +: W].
module mux4x1_lane_sel
    import mux4x1_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [NUM_LANES*W-1:0] din,
    input  logic [SEL_W-1:0]       sel,
    output logic [W-1:0]           lane
);
    logic [NUM_LANES-1:0][W-1:0] lanes;
    logic [NUM_LANES-1:0][W-1:0] masked;
    sel_t                        s;

    assign lanes = din;
    assign s     = sel;

    // AND-OR mux: each lane is gated by its own decode, then OR-reduced.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign masked[g] = lanes[g] & {W{s == sel_t'(g)}};
    end

    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane = lane | masked[i];
        end
    end
endmodule

// File: rtl/mux4x1_reg.sv
// Registered 4:1 lane multiplexer with valid flag, one cycle latency.
// Define MUX4X1_COMB_OUT_EN to add the zero-latency dout_comb output.
module mux4x1_reg
    import mux4x1_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LANES*W-1:0] din,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic [W-1:0]           dout,
`ifdef MUX4X1_COMB_OUT_EN
    output logic [W-1:0]           dout_comb,
`endif
    output logic                   out_valid
);
    logic [W-1:0] lane;

    mux4x1_lane_sel #(.W(W)) u_sel (
        .din  (din),
        .sel  (sel),
        .lane (lane)
    );

`ifdef MUX4X1_COMB_OUT_EN
    assign dout_comb = lane;
`endif

    // dout only loads on valid, so an unknown sel while idle never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout <= lane;
            end
        end
    end
endmodule

// File: tb/tb_mux4x1_reg.sv
// Self-checking bench for mux4x1_reg: W=1 and W=8 instances, table vectors,
// directed corner sequences and a randomized run against a shift-based model.
module tb_mux4x1_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  din1;
    logic [1:0]  sel1;
    logic        vld1;
    logic [0:0]  dout1;
    logic        ov1;

    logic [31:0] din8;
    logic [1:0]  sel8;
    logic        vld8;
    logic [7:0]  dout8;
    logic        ov8;

`ifdef MUX4X1_COMB_OUT_EN
    logic [0:0]  comb1;
    logic [7:0]  comb8;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4x1_reg #(.W(1)) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din1),
        .sel       (sel1),
        .in_valid  (vld1),
        .dout      (dout1),
`ifdef MUX4X1_COMB_OUT_EN
        .dout_comb (comb1),
`endif
        .out_valid (ov1)
    );

    mux4x1_reg #(.W(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din8),
        .sel       (sel8),
        .in_valid  (vld8),
        .dout      (dout8),
`ifdef MUX4X1_COMB_OUT_EN
        .dout_comb (comb8),
`endif
        .out_valid (ov8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] din;
        logic [1:0] sel;
        logic       vld;
        logic       exp_d;
        logic       exp_v;
    } vec_t;

    vec_t        tbl[18];
    logic [7:0]  exp8[4];
    logic [7:0]  md;
    logic        mv;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        rv;

    initial begin
        din1 = '0; sel1 = '0; vld1 = 1'b0;
        din8 = '0; sel8 = '0; vld8 = 1'b0;

        // Walking one across each lane, then a capture followed by a hold.
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) begin
                tbl[k*4+s].din   = 4'(1 << k);
                tbl[k*4+s].sel   = 2'(s);
                tbl[k*4+s].vld   = 1'b1;
                tbl[k*4+s].exp_d = (k == s);
                tbl[k*4+s].exp_v = 1'b1;
            end
        end
        tbl[16] = '{din: 4'b1000, sel: 2'd3, vld: 1'b1, exp_d: 1'b1, exp_v: 1'b1};
        tbl[17] = '{din: 4'b0000, sel: 2'd0, vld: 1'b0, exp_d: 1'b1, exp_v: 1'b0};
        exp8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Reset held with inputs toggling: outputs stay zero.
        #1;
        check("rst_async_dout8", 32'(dout8), 32'h0);
        check("rst_async_ov8", 32'(ov8), 32'h0);
        for (int i = 0; i < 6; i++) begin
            din1 = 4'($urandom); sel1 = 2'($urandom); vld1 = 1'($urandom);
            din8 = $urandom;     sel8 = 2'($urandom); vld8 = 1'($urandom);
            @(posedge clk); #1;
            check("rst_hold_dout1", 32'(dout1), 32'h0);
            check("rst_hold_ov1", 32'(ov1), 32'h0);
            check("rst_hold_dout8", 32'(dout8), 32'h0);
            check("rst_hold_ov8", 32'(ov8), 32'h0);
        end
        vld1 = 1'b0; vld8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_dout1", 32'(dout1), 32'h0);
        check("post_rst_ov1", 32'(ov1), 32'h0);
        check("post_rst_dout8", 32'(dout8), 32'h0);
        check("post_rst_ov8", 32'(ov8), 32'h0);

        // Table vectors on the W=1 instance.
        for (int i = 0; i < 18; i++) begin
            din1 = tbl[i].din; sel1 = tbl[i].sel; vld1 = tbl[i].vld;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_dout", i), 32'(dout1), 32'(tbl[i].exp_d));
            check($sformatf("tbl%0d_ov", i), 32'(ov1), 32'(tbl[i].exp_v));
        end
        vld1 = 1'b0;

        // W=8 back-to-back lane sweep.
        din8 = 32'hDDCCBBAA; vld8 = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel8 = 2'(s);
            @(posedge clk); #1;
            check($sformatf("w8_sel%0d_dout", s), 32'(dout8), 32'(exp8[s]));
            check($sformatf("w8_sel%0d_ov", s), 32'(ov8), 32'h1);
        end

        // Mid-cycle input changes are ignored; async reset clears before the next edge.
        sel8 = 2'd2;
        @(posedge clk); #1;
        din8 = 32'h12345678; sel8 = 2'd0;
        #1;
        check("between_edges_dout8", 32'(dout8), 32'hCC);
        check("pre_rst_ov8", 32'(ov8), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_dout8", 32'(dout8), 32'h0);
        check("async_rst_ov8", 32'(ov8), 32'h0);
        check("async_rst_dout1", 32'(dout1), 32'h0);
        vld8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX4X1_COMB_OUT_EN
        // Combinational output follows sel between edges; registered output untouched.
        @(posedge clk); #1;
        din1 = 4'b0100; vld1 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel1 = 2'(s);
            #1;
            check($sformatf("comb_sel%0d", s), 32'(comb1), 32'(s == 2));
            check($sformatf("comb_hold%0d", s), 32'(dout1), 32'h0);
        end
        din8 = 32'hDDCCBBAA; sel8 = 2'd1;
        #1;
        check("comb8", 32'(comb8), 32'hBB);
`endif

        // Randomized run, including unknown sel while idle.
        @(posedge clk); #1;
        md = 8'h0; mv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            rs = 2'($urandom);
            din8 = rd; vld8 = rv;
            sel8 = (!rv && $urandom_range(0, 1) == 1) ? 2'bxx : rs;
            @(posedge clk); #1;
            if (rv) md = 8'(rd >> (int'(rs) * 8));
            mv = rv;
            check("rand_dout8", 32'(dout8), 32'(md));
            check("rand_ov8", 32'(ov8), 32'(mv));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
